// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_cmd_ctrl
// Description : Byte-stream command sequencer for the shared ALU. It loads the
//               operands and function code, pulses the ALU enable, captures the
//               16-bit result and returns it as two bytes over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
  parameter int WIDTH = 8,
  parameter int FUNC  = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [WIDTH-1:0]   RX_DATA,
  input  logic               RX_VALID,
  input  logic [2*WIDTH-1:0] ALU_OUT,
  input  logic               ALU_VALID,
  input  logic               TX_READY,
  output logic [WIDTH-1:0]   ALU_A,
  output logic [WIDTH-1:0]   ALU_B,
  output logic [FUNC-1:0]    ALU_FUN,
  output logic               ALU_EN,
  output logic [WIDTH-1:0]   TX_DATA,
  output logic               TX_VALID,
  output logic               BUSY,
  output logic               CMD_ERR,
  output logic               OVERRUN
);

  localparam logic [2:0] c_IDLE     = 3'd0;
  localparam logic [2:0] c_GET_A    = 3'd1;
  localparam logic [2:0] c_GET_B    = 3'd2;
  localparam logic [2:0] c_GET_FUN  = 3'd3;
  localparam logic [2:0] c_ALU_RUN  = 3'd4;
  localparam logic [2:0] c_ALU_WAIT = 3'd5;
  localparam logic [2:0] c_SEND_LO  = 3'd6;
  localparam logic [2:0] c_SEND_HI  = 3'd7;

  localparam logic [WIDTH-1:0] c_CMD_FULL  = WIDTH'(8'hCC);
  localparam logic [WIDTH-1:0] c_CMD_REUSE = WIDTH'(8'hDD);

  logic [2:0]         r_state;
  logic [2:0]         w_state_next;
  logic [WIDTH-1:0]   r_alu_a;
  logic [WIDTH-1:0]   r_alu_b;
  logic [FUNC-1:0]    r_alu_fun;
  logic [2*WIDTH-1:0] r_result;
  logic               r_cmd_err;
  logic               r_overrun;
  logic               w_unknown_cmd;
  logic               w_rx_unexpected;

  assign w_unknown_cmd = (r_state == c_IDLE) && RX_VALID &&
                         (RX_DATA != c_CMD_FULL) && (RX_DATA != c_CMD_REUSE);

  // The back half of the state encoding (RUN..SEND_HI) never consumes bytes.
  assign w_rx_unexpected = RX_VALID && r_state[2];

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE: begin
        if (RX_VALID && (RX_DATA == c_CMD_FULL)) begin
          w_state_next = c_GET_A;
        end else if (RX_VALID && (RX_DATA == c_CMD_REUSE)) begin
          w_state_next = c_GET_FUN;
        end
      end
      c_GET_A:    if (RX_VALID)  w_state_next = c_GET_B;
      c_GET_B:    if (RX_VALID)  w_state_next = c_GET_FUN;
      c_GET_FUN:  if (RX_VALID)  w_state_next = c_ALU_RUN;
      c_ALU_RUN:                 w_state_next = c_ALU_WAIT;
      c_ALU_WAIT: if (ALU_VALID) w_state_next = c_SEND_LO;
      c_SEND_LO:  if (TX_READY)  w_state_next = c_SEND_HI;
      c_SEND_HI:  if (TX_READY)  w_state_next = c_IDLE;
      default:                   w_state_next = c_IDLE;
    endcase
  end

  // Operand, function and result registers plus the status pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_result  <= '0;
      r_cmd_err <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cmd_err <= w_unknown_cmd;
      r_overrun <= w_rx_unexpected;
      if (RX_VALID && (r_state == c_GET_A)) begin
        r_alu_a <= RX_DATA;
      end
      if (RX_VALID && (r_state == c_GET_B)) begin
        r_alu_b <= RX_DATA;
      end
      if (RX_VALID && (r_state == c_GET_FUN)) begin
        r_alu_fun <= RX_DATA[FUNC-1:0];
      end
      if (ALU_VALID && (r_state == c_ALU_WAIT)) begin
        r_result <= ALU_OUT;
      end
    end
  end

  // Output decode from registered state only
  always_comb begin
    ALU_EN   = 1'b0;
    TX_VALID = 1'b0;
    BUSY     = 1'b1;
    TX_DATA  = r_result[WIDTH-1:0];
    case (r_state)
      c_IDLE:    BUSY     = 1'b0;
      c_ALU_RUN: ALU_EN   = 1'b1;
      c_SEND_LO: TX_VALID = 1'b1;
      c_SEND_HI: begin
        TX_VALID = 1'b1;
        TX_DATA  = r_result[2*WIDTH-1:WIDTH];
      end
      default: ;
    endcase
  end

  assign ALU_A   = r_alu_a;
  assign ALU_B   = r_alu_b;
  assign ALU_FUN = r_alu_fun;
  assign CMD_ERR = r_cmd_err;
  assign OVERRUN = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_cmd_ctrl
// Description : Directed self-checking bench for alu_cmd_ctrl with a small
//               registered ALU model (0 add, 1 sub, 2 mul, else xor).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic [15:0] ALU_OUT;
  logic        ALU_VALID;
  logic        TX_READY = 1'b1;
  logic [7:0]  ALU_A, ALU_B, TX_DATA;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN, TX_VALID, BUSY, CMD_ERR, OVERRUN;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int ovr_cnt = 0;
  logic [7:0] tx_q[$];

  alu_cmd_ctrl #(.WIDTH(8), .FUNC(4)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .ALU_OUT(ALU_OUT), .ALU_VALID(ALU_VALID), .TX_READY(TX_READY),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .BUSY(BUSY),
    .CMD_ERR(CMD_ERR), .OVERRUN(OVERRUN)
  );

  always #5 CLK = ~CLK;

  // Registered ALU model: result and valid appear the cycle after enable
  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ALU_VALID <= 1'b0;
      ALU_OUT   <= '0;
    end else begin
      ALU_VALID <= ALU_EN;
      if (ALU_EN) begin
        case (ALU_FUN)
          4'd0:    ALU_OUT <= {8'h00, ALU_A} + {8'h00, ALU_B};
          4'd1:    ALU_OUT <= {8'h00, ALU_A} - {8'h00, ALU_B};
          4'd2:    ALU_OUT <= ALU_A * ALU_B;
          default: ALU_OUT <= {8'h00, ALU_A ^ ALU_B};
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (ALU_EN)   en_cnt++;
    if (CMD_ERR)  err_cnt++;
    if (OVERRUN)  ovr_cnt++;
    if (TX_VALID && TX_READY) tx_q.push_back(TX_DATA);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_DATA  = b;
    RX_VALID = 1'b1;
    tick();
    RX_VALID = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (BUSY && n < 60) begin
      tick();
      n++;
    end
    chk({tag, "_idle"}, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic chk_tx(input string tag, input int base, input logic [7:0] lo, input logic [7:0] hi);
    logic [7:0] g_lo, g_hi;
    g_lo = (tx_q.size() > base)     ? tx_q[base]     : 8'hxx;
    g_hi = (tx_q.size() > base + 1) ? tx_q[base + 1] : 8'hxx;
    chk({tag, "_ntx"}, tx_q.size() - base, 32'd2);
    chk({tag, "_lo"}, {24'd0, g_lo}, {24'd0, lo});
    chk({tag, "_hi"}, {24'd0, g_hi}, {24'd0, hi});
  endtask

  task automatic full_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] f, input logic [7:0] lo, input logic [7:0] hi);
    int base = tx_q.size();
    int en0  = en_cnt;
    send_byte(8'hCC); send_byte(a); send_byte(b); send_byte(f);
    wait_idle(tag);
    chk_tx(tag, base, lo, hi);
    chk({tag, "_en"}, en_cnt - en0, 32'd1);
  endtask

  initial begin
    int base;
    int en0;
    // Reset state
    tick(); tick(); tick();
    chk("rst_a",   {24'd0, ALU_A}, 32'd0);
    chk("rst_b",   {24'd0, ALU_B}, 32'd0);
    chk("rst_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("rst_tx",  {24'd0, TX_DATA}, 32'd0);
    chk("rst_ctl", {27'd0, ALU_EN, TX_VALID, BUSY, CMD_ERR, OVERRUN}, 32'd0);
    RST = 1'b1;
    tick();

    // Basic add
    full_frame("add", 8'h05, 8'h03, 8'h00, 8'h08, 8'h00);
    chk("add_fun", {28'd0, ALU_FUN}, 32'd0);
    chk("add_a",   {24'd0, ALU_A}, 32'h05);
    chk("add_b",   {24'd0, ALU_B}, 32'h03);

    // Cycle-accurate latency with TX_READY tied high, started with no gap
    send_byte(8'hCC); send_byte(8'h02); send_byte(8'h03); send_byte(8'h00);
    chk("cyc_t1_en", {30'd0, ALU_EN, TX_VALID}, 32'b10);
    tick();
    chk("cyc_t2",    {30'd0, ALU_EN, TX_VALID}, 32'b00);
    tick();
    chk("cyc_t3_v",  {31'd0, TX_VALID}, 32'd1);
    chk("cyc_t3_d",  {24'd0, TX_DATA}, 32'h05);
    tick();
    chk("cyc_t4_v",  {31'd0, TX_VALID}, 32'd1);
    chk("cyc_t4_d",  {24'd0, TX_DATA}, 32'h00);
    tick();
    chk("cyc_t5",    {30'd0, BUSY, TX_VALID}, 32'd0);

    // Multiply with a five-cycle stall on the low byte and an overrun strobe
    base = tx_q.size();
    send_byte(8'hCC); send_byte(8'h0F); send_byte(8'h0F);
    TX_READY = 1'b0;
    send_byte(8'h02);
    tick(); tick();
    chk("stall0", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hE1});
    tick();
    chk("stall1", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hE1});
    send_byte(8'h55);
    chk("stall2", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hE1});
    chk("ovr_pulse", {31'd0, OVERRUN}, 32'd1);
    tick();
    chk("stall3", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hE1});
    chk("ovr_clear", {31'd0, OVERRUN}, 32'd0);
    tick();
    chk("stall4", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hE1});
    chk("ovr_noload", {24'd0, ALU_A}, 32'h0F);
    TX_READY = 1'b1;
    wait_idle("mul");
    chk_tx("mul", base, 8'hE1, 8'h00);

    // Subtract, then reuse stored operands with an add
    full_frame("sub", 8'h09, 8'h04, 8'h01, 8'h05, 8'h00);
    base = tx_q.size();
    en0  = en_cnt;
    send_byte(8'hDD); send_byte(8'hF0);
    wait_idle("reuse");
    chk_tx("reuse", base, 8'h0D, 8'h00);
    chk("reuse_en", en_cnt - en0, 32'd1);
    chk("reuse_ab", {16'd0, ALU_A, ALU_B}, 32'h0904);

    // Unknown command byte
    en0 = en_cnt;
    send_byte(8'h7A);
    chk("cmderr_pulse", {30'd0, CMD_ERR, BUSY}, 32'b10);
    tick();
    chk("cmderr_clear", {31'd0, CMD_ERR}, 32'd0);
    chk("cmderr_noen", en_cnt - en0, 32'd0);
    full_frame("after_err", 8'h02, 8'h02, 8'h00, 8'h04, 8'h00);

    // Asynchronous reset while waiting for operand B
    en0  = en_cnt;
    base = tx_q.size();
    send_byte(8'hCC); send_byte(8'h11);
    chk("getb_a", {24'd0, ALU_A}, 32'h11);
    #2 RST = 1'b0;
    #1;
    chk("arst_ab",  {16'd0, ALU_A, ALU_B}, 32'd0);
    chk("arst_ctl", {27'd0, ALU_EN, TX_VALID, BUSY, CMD_ERR, OVERRUN}, 32'd0);
    chk("arst_tx",  {24'd0, TX_DATA}, 32'd0);
    tick(); tick(); tick();
    RST = 1'b1;
    tick(); tick();
    chk("arst_quiet", (en_cnt - en0) + (tx_q.size() - base), 32'd0);
    full_frame("post_rst", 8'h01, 8'h01, 8'h00, 8'h02, 8'h00);

    chk("tot_cmderr", err_cnt, 32'd1);
    chk("tot_ovr",    ovr_cnt, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
